mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Multicycle memory controller between CPU address/data path and single-port synchronous SRAM.
//  Downstream of the CPU address mux (Addr) and RegB (W_data); upstream of MDR (R_data) and CU (Mem_busy, MemWrong).
//  Checks alignment/range, steers store lanes, inserts wait states, holds read data until the next read completes.
// PARAMETERS
//  ADDR_W       12      SRAM word-address width (4*2^ADDR_W bytes)
//  WAIT_STATES  1       extra cycles per SRAM access, 0..15
//  BASE_ADDR    32'h0   byte base of window; Addr[31:ADDR_W+2] must equal BASE_ADDR[31:ADDR_W+2]
// PORTS
//  CLK        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  Addr       in   32      byte address
//  MemRd      in   1       read strobe, level
//  MemWr      in   1       write strobe, level
//  Type       in   2       00 word, 01 half, 10 byte, 11 reserved
//  W_data     in   32      store data, right-justified
//  R_data     out  32      full aligned word; lane extraction is downstream
//  Mem_busy   out  1       access in progress; CU holds all request inputs stable while high
//  MemWrong   out  2       00 ok, 01 misaligned load, 10 misaligned store, 11 range/illegal
//  sram_en    out  1       SRAM enable
//  sram_we    out  4       SRAM byte write enables, bit i = byte lane i
//  sram_addr  out  ADDR_W  SRAM word address = Addr[ADDR_W+1:2]
//  sram_wdata out  32      lane-steered store data
//  sram_rdata in   32      SRAM read data, valid one cycle after sram_en
// BEHAVIOUR
//  Reset (async): state IDLE, armed=1, R_data=0, Mem_busy=0, MemWrong=00, sram_en=0, sram_we=0.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//  Accept rule: IDLE && armed && (MemRd|MemWr) at a rising edge.
//  Checks at accept, in this priority:
//   - MemRd&MemWr, Type=11, or out-of-window -> MemWrong=11.
//   - half with Addr[0]!=0, or word with Addr[1:0]!=0 -> 01 (read) / 10 (write).
//   - On any error: no SRAM cycle, Mem_busy stays 0, armed cleared, MemWrong valid from the next cycle.
//  Good accept: MemWrong=00; sram_en=1 and, for writes, sram_we/sram_wdata registered at the same edge.
//   Mem_busy=1 from that edge; cnt=WAIT_STATES; go to WAIT.
//  WAIT: cnt decrements each cycle; go to RESP at cnt==0. sram_en/sram_we are held for the whole access.
//  RESP: reads latch sram_rdata into R_data. Mem_busy=0, sram_en=0, sram_we=0, armed=0; go to IDLE.
//  Latency: Mem_busy high for exactly WAIT_STATES+1 cycles.
//  R_data changes only at read completion; writes and errors leave it unchanged.
//  Re-arm: armed sets after a cycle with MemRd=MemWr=0, so a held strobe never retriggers.
//  Store steering:
//   - byte: W_data[7:0] replicated to all lanes, we=1<<Addr[1:0].
//   - half: W_data[15:0] replicated, we=Addr[1]?1100:0011.
//   - word: we=1111.
//  MemWrong holds until the next accepted request.
//  Reset mid-access aborts; sram_we drops asynchronously, so a partial write may or may not land.
// CONFIGURATION
//  MEMCTRL_WBUF_EN defined: one-entry posted write buffer.
//   - Good write in IDLE with empty buffer: captured, Mem_busy stays 0, buffer drains in the background (WAIT_STATES+1 cycles).
//   - Write or read accepted while the buffer is full: Mem_busy=1 until drain completes, then normal access.
//   - Read latency extends accordingly; a read always observes buffered data.
//  MEMCTRL_WBUF_EN undefined: writes are blocking as above.
// STRUCTURE
//  mem_ctrl_pkg: Type codes, MemWrong codes, FSM state encoding.
//  Sub-module mem_ctrl_lane: combinational store steering and byte-enable generation.
//  Error checks and FSM stay in mem_ctrl.
// TESTING
//  1 WAIT_STATES=1: read word Addr=0x10 with SRAM word4=0xDEADBEEF -> Mem_busy 2 cycles, R_data=0xDEADBEEF, MemWrong=00.
//  2 Write byte 0xA5 to Addr=0x13 -> sram_we=1000, sram_wdata=0xA5A5A5A5; half to 0x12 -> we=1100.
//  3 Read half at 0x11 -> MemWrong=01, sram_en never 1, Mem_busy 0; word write at 0x2 -> MemWrong=10.
//  4 Addr=0x0001_0000 (ADDR_W=12) or MemRd=MemWr=1 -> MemWrong=11, no SRAM activity, R_data unchanged.
//  5 Hold MemRd high 10 cycles -> exactly one access; drop 1 cycle then reassert -> second access.
//  6 Assert rst_n=0 during WAIT of a write -> sram_we=0 immediately; all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the multicycle memory controller: access types, error codes, FSM states.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        TYPE_WORD = 2'b00,
        TYPE_HALF = 2'b01,
        TYPE_BYTE = 2'b10,
        TYPE_RSVD = 2'b11
    } mem_type_e;

    typedef enum logic [1:0] {
        ERR_OK          = 2'b00,
        ERR_LOAD_ALIGN  = 2'b01,
        ERR_STORE_ALIGN = 2'b10,
        ERR_ILLEGAL     = 2'b11
    } mem_err_e;

    // ST_HOLD is only reachable when the posted write buffer is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

    localparam int CNT_W = 4;

    function automatic logic is_misaligned(input logic [1:0] mem_type, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (mem_type == TYPE_HALF)
            bad = addr_lo[0];
        else if (mem_type == TYPE_WORD)
            bad = (addr_lo != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/mem_ctrl_lane.sv
// Store lane steering: replicates byte/half data across lanes and builds per-lane write enables.
module mem_ctrl_lane
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mem_type,
    input  logic [31:0] w_data,
    output logic [3:0]  lane_we,
    output logic [31:0] lane_wdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_bit;
            logic [7:0] lane_byte;

            always_comb begin
                lane_bit  = 1'b0;
                lane_byte = w_data[8*gi +: 8];
                case (mem_type)
                    TYPE_BYTE: begin
                        lane_bit  = (addr_lo == LANE);
                        lane_byte = w_data[7:0];
                    end
                    TYPE_HALF: begin
                        lane_bit  = (addr_lo[1] == LANE[1]);
                        lane_byte = w_data[8*(gi%2) +: 8];
                    end
                    TYPE_WORD: begin
                        lane_bit  = 1'b1;
                    end
                    default: begin
                        lane_bit  = 1'b0;
                    end
                endcase
            end

            assign lane_we[gi]           = lane_bit;
            assign lane_wdata[8*gi +: 8] = lane_byte;
        end
    endgenerate

endmodule

// File: rtl/mem_ctrl.sv
// Multicycle CPU-to-SRAM controller with alignment/range checks and wait-state insertion.
// Optional MEMCTRL_WBUF_EN adds a one-entry posted write buffer that drains in the background.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
)
(
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [31:0]       Addr,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [1:0]        Type,
    input  logic [31:0]       W_data,
    output logic [31:0]       R_data,
    output logic              Mem_busy,
    output logic [1:0]        MemWrong,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               armed_reg, armed_next;
    logic               busy_reg, busy_next;
    logic               is_read_reg, is_read_next;
    mem_err_e           wrong_reg, wrong_next;
    logic [31:0]        r_data_reg, r_data_next;
    logic               sram_en_reg, sram_en_next;
    logic [3:0]         sram_we_reg, sram_we_next;
    logic [ADDR_W-1:0]  sram_addr_reg, sram_addr_next;
    logic [31:0]        sram_wdata_reg, sram_wdata_next;

    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic        strobe;
    logic        accept;
    logic        in_window;
    logic        start_access;
    mem_err_e    req_err;

`ifdef MEMCTRL_WBUF_EN
    logic             drain_reg, drain_next;
    logic [CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
`endif

    mem_ctrl_lane u_lane (
        .addr_lo    (Addr[1:0]),
        .mem_type   (Type),
        .w_data     (W_data),
        .lane_we    (lane_we),
        .lane_wdata (lane_wdata)
    );

    assign strobe    = MemRd | MemWr;
    assign accept    = (state_reg == ST_IDLE) && armed_reg && strobe;
    assign in_window = (Addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

    always_comb begin
        req_err = ERR_OK;
        if ((MemRd && MemWr) || (Type == TYPE_RSVD) || !in_window)
            req_err = ERR_ILLEGAL;
        else if (is_misaligned(Type, Addr[1:0]))
            req_err = MemWr ? ERR_STORE_ALIGN : ERR_LOAD_ALIGN;
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        armed_next      = armed_reg;
        busy_next       = busy_reg;
        is_read_next    = is_read_reg;
        wrong_next      = wrong_reg;
        r_data_next     = r_data_reg;
        sram_en_next    = sram_en_reg;
        sram_we_next    = sram_we_reg;
        sram_addr_next  = sram_addr_reg;
        sram_wdata_next = sram_wdata_reg;
        start_access    = 1'b0;

`ifdef MEMCTRL_WBUF_EN
        drain_next     = drain_reg;
        drain_cnt_next = drain_cnt_reg;
        // Background drain owns the SRAM port until its counter expires.
        if (drain_reg) begin
            if (drain_cnt_reg == '0) begin
                drain_next   = 1'b0;
                sram_en_next = 1'b0;
                sram_we_next = 4'b0000;
            end else begin
                drain_cnt_next = drain_cnt_reg - CNT_W'(1);
            end
        end
`endif

        // A strobe-free cycle re-arms, so a level held across completion never retriggers.
        if (!strobe)
            armed_next = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    armed_next = 1'b0;
                    wrong_next = req_err;
                    if (req_err == ERR_OK) begin
`ifdef MEMCTRL_WBUF_EN
                        if (drain_reg) begin
                            busy_next  = 1'b1;
                            state_next = ST_HOLD;
                        end else if (MemWr) begin
                            sram_en_next    = 1'b1;
                            sram_we_next    = lane_we;
                            sram_addr_next  = Addr[ADDR_W+1:2];
                            sram_wdata_next = lane_wdata;
                            drain_next      = 1'b1;
                            drain_cnt_next  = WAIT_CNT;
                        end else begin
                            start_access = 1'b1;
                        end
`else
                        start_access = 1'b1;
`endif
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next   = ST_RESP;
                    busy_next    = 1'b0;
                    sram_en_next = 1'b0;
                    sram_we_next = 4'b0000;
                    if (is_read_reg)
                        r_data_next = sram_rdata;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
`ifdef MEMCTRL_WBUF_EN
            ST_HOLD: begin
                // Request inputs are held stable by the CU while busy, so no capture is needed.
                if (!drain_reg || (drain_cnt_reg == '0))
                    start_access = 1'b1;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (start_access) begin
            state_next      = ST_WAIT;
            busy_next       = 1'b1;
            cnt_next        = WAIT_CNT;
            is_read_next    = MemRd;
            sram_en_next    = 1'b1;
            sram_we_next    = MemWr ? lane_we : 4'b0000;
            sram_addr_next  = Addr[ADDR_W+1:2];
            sram_wdata_next = lane_wdata;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            armed_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            is_read_reg    <= 1'b0;
            wrong_reg      <= ERR_OK;
            r_data_reg     <= '0;
            sram_en_reg    <= 1'b0;
            sram_we_reg    <= 4'b0000;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            armed_reg      <= armed_next;
            busy_reg       <= busy_next;
            is_read_reg    <= is_read_next;
            wrong_reg      <= wrong_next;
            r_data_reg     <= r_data_next;
            sram_en_reg    <= sram_en_next;
            sram_we_reg    <= sram_we_next;
            sram_addr_reg  <= sram_addr_next;
            sram_wdata_reg <= sram_wdata_next;
        end
    end

`ifdef MEMCTRL_WBUF_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            drain_reg     <= 1'b0;
            drain_cnt_reg <= '0;
        end else begin
            drain_reg     <= drain_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end
`endif

    assign R_data     = r_data_reg;
    assign Mem_busy   = busy_reg;
    assign MemWrong   = wrong_reg;
    assign sram_en    = sram_en_reg;
    assign sram_we    = sram_we_reg;
    assign sram_addr  = sram_addr_reg;
    assign sram_wdata = sram_wdata_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl (WAIT_STATES=1, ADDR_W=12) against a registered-output SRAM model.
module tb_mem_ctrl;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Addr;
    logic        MemRd;
    logic        MemWr;
    logic [1:0]  Type;
    logic [31:0] W_data;
    logic [31:0] R_data;
    logic        Mem_busy;
    logic [1:0]  MemWrong;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    always #5 CLK = ~CLK;

    mem_ctrl #(
        .ADDR_W      (12),
        .WAIT_STATES (1),
        .BASE_ADDR   (32'h0)
    ) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .Addr       (Addr),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .Type       (Type),
        .W_data     (W_data),
        .R_data     (R_data),
        .Mem_busy   (Mem_busy),
        .MemWrong   (MemWrong),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    logic [31:0] sram [0:4095];

    always @(posedge CLK) begin
        if (sram_en) begin
            for (int i = 0; i < 4; i++)
                if (sram_we[i])
                    sram[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            sram_rdata <= sram[sram_addr];
        end
    end

    int          busy_total = 0;
    int          en_rises = 0;
    logic        en_prev = 1'b0;
    logic [3:0]  last_we = 4'b0000;
    logic [31:0] last_wdata = 32'h0;

    always @(negedge CLK) begin
        if (Mem_busy) busy_total++;
        if (sram_en && !en_prev) en_rises++;
        en_prev = sram_en;
        if (sram_en && (sram_we != 4'b0000)) begin
            last_we    = sram_we;
            last_wdata = sram_wdata;
        end
    end

    int checks = 0;
    int errors = 0;
    int busy_d;
    int en_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [1:0] typ, input logic [31:0] wd);
        int b0;
        int e0;
        int n;
        b0 = busy_total;
        e0 = en_rises;
        MemRd  = rd;
        MemWr  = wr;
        Addr   = addr;
        Type   = typ;
        W_data = wd;
        @(posedge CLK); #1;
        n = 0;
        while (Mem_busy && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 50) check("busy_timeout", 32'(Mem_busy), 32'd0);
        MemRd = 1'b0;
        MemWr = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        busy_d = busy_total - b0;
        en_d   = en_rises - e0;
        $display("txn rd=%0d wr=%0d addr=%h type=%0d wdata=%h -> rdata=%h wrong=%0d busy=%0d en=%0d",
                 rd, wr, addr, typ, wd, R_data, MemWrong, busy_d, en_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        MemRd  = 1'b0;
        MemWr  = 1'b0;
        Addr   = 32'h0;
        Type   = 2'b00;
        W_data = 32'h0;

        #12;
        check("rst_rdata", R_data, 32'h0);
        check("rst_busy", 32'(Mem_busy), 32'd0);
        check("rst_wrong", 32'(MemWrong), 32'd0);
        check("rst_en", 32'(sram_en), 32'd0);
        check("rst_we", 32'(sram_we), 32'd0);
        #6 rst_n = 1'b1;
        @(posedge CLK); #1;

        // Preload word 4 through the controller.
        xfer(1'b0, 1'b1, 32'h10, 2'b00, 32'hDEADBEEF);
        check("wr_word_we", 32'(last_we), 32'hF);
        check("wr_word_data", last_wdata, 32'hDEADBEEF);
        check("wr_word_busy", busy_d, 2);
        check("wr_word_wrong", 32'(MemWrong), 32'd0);
        check("wr_rdata_hold", R_data, 32'h0);

        xfer(1'b1, 1'b0, 32'h10, 2'b00, 32'h0);
        check("rd_word_data", R_data, 32'hDEADBEEF);
        check("rd_word_busy", busy_d, 2);
        check("rd_word_en", en_d, 1);
        check("rd_word_wrong", 32'(MemWrong), 32'd0);

        xfer(1'b0, 1'b1, 32'h13, 2'b10, 32'h000000A5);
        check("wr_byte3_we", 32'(last_we), 32'h8);
        check("wr_byte3_data", last_wdata, 32'hA5A5A5A5);
        check("wr_byte_rdata", R_data, 32'hDEADBEEF);

        xfer(1'b0, 1'b1, 32'h12, 2'b01, 32'h00001234);
        check("wr_half_hi_we", 32'(last_we), 32'hC);
        check("wr_half_hi_data", last_wdata, 32'h12341234);

        xfer(1'b0, 1'b1, 32'h10, 2'b01, 32'h0000ABCD);
        check("wr_half_lo_we", 32'(last_we), 32'h3);
        check("wr_half_lo_data", last_wdata, 32'hABCDABCD);

        xfer(1'b0, 1'b1, 32'h11, 2'b10, 32'hFFFFFF5A);
        check("wr_byte1_we", 32'(last_we), 32'h2);
        check("wr_byte1_data", last_wdata, 32'h5A5A5A5A);

        xfer(1'b1, 1'b0, 32'h10, 2'b00, 32'h0);
        check("rd_merged", R_data, 32'h12345ACD);

        xfer(1'b1, 1'b0, 32'h11, 2'b01, 32'h0);
        check("mis_ld_wrong", 32'(MemWrong), 32'h1);
        check("mis_ld_en", en_d, 0);
        check("mis_ld_busy", busy_d, 0);
        check("mis_ld_rdata", R_data, 32'h12345ACD);

        xfer(1'b0, 1'b1, 32'h2, 2'b00, 32'h11111111);
        check("mis_st_wrong", 32'(MemWrong), 32'h2);
        check("mis_st_en", en_d, 0);

        xfer(1'b1, 1'b0, 32'h13, 2'b10, 32'h0);
        check("rd_byte_wrong", 32'(MemWrong), 32'h0);
        check("rd_byte_word", R_data, 32'h12345ACD);

        xfer(1'b1, 1'b0, 32'h0001_0000, 2'b00, 32'h0);
        check("range_wrong", 32'(MemWrong), 32'h3);
        check("range_en", en_d, 0);
        check("range_rdata", R_data, 32'h12345ACD);

        xfer(1'b1, 1'b1, 32'h10, 2'b00, 32'h0);
        check("rdwr_wrong", 32'(MemWrong), 32'h3);
        check("rdwr_en", en_d, 0);

        xfer(1'b1, 1'b0, 32'h10, 2'b11, 32'h0);
        check("rsvd_wrong", 32'(MemWrong), 32'h3);
        check("rsvd_busy", busy_d, 0);

        // Held strobe: one access only; a single idle cycle re-arms.
        begin
            int e0;
            e0 = en_rises;
            MemRd = 1'b1;
            Addr  = 32'h10;
            Type  = 2'b00;
            repeat (10) @(posedge CLK);
            #1;
            check("hold_one_access", en_rises - e0, 1);
            check("hold_wrong", 32'(MemWrong), 32'h0);
            MemRd = 1'b0;
            @(posedge CLK); #1;
            MemRd = 1'b1;
            repeat (6) @(posedge CLK);
            #1;
            MemRd = 1'b0;
            repeat (2) @(posedge CLK);
            #1;
            check("rearm_second", en_rises - e0, 2);
            $display("txn hold rd addr=00000010 -> accesses=%0d rdata=%h", en_rises - e0, R_data);
        end

        // Reset during the wait phase of a write.
        MemWr  = 1'b1;
        Addr   = 32'h30;
        Type   = 2'b00;
        W_data = 32'h11112222;
        @(posedge CLK); #1;
        check("pre_rst_we", 32'(sram_we), 32'hF);
        check("pre_rst_busy", 32'(Mem_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", 32'(sram_we), 32'h0);
        check("arst_en", 32'(sram_en), 32'd0);
        check("arst_busy", 32'(Mem_busy), 32'd0);
        check("arst_rdata", R_data, 32'h0);
        check("arst_wrong", 32'(MemWrong), 32'd0);
        MemWr = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge CLK); #1;
        $display("txn reset during write wait -> we=%b busy=%0d", sram_we, Mem_busy);

        xfer(1'b1, 1'b0, 32'h10, 2'b00, 32'h0);
        check("post_rst_rdata", R_data, 32'h12345ACD);
        check("post_rst_busy", busy_d, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
